// File: rtl/dotinator_pkg.sv
// dotinator_pkg: shared FSM state type and sizing helpers for seq_matrix_multiplier
package dotinator_pkg;

    typedef enum logic [1:0] {LOAD, COMPUTE, OUTPUT} state_e;

    // Index width for a range of n values; never collapses to zero bits.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Total number of load words: all of A followed by all of B.
    function automatic int load_words(input int n_rows, input int n_cols, input int m_cols);
        return n_rows * n_cols + n_cols * m_cols;
    endfunction

endpackage

// File: rtl/seq_matrix_multiplier_if.sv
// seq_matrix_multiplier_if: load stream, result stream and status of the sequential matrix multiplier
interface seq_matrix_multiplier_if
    import dotinator_pkg::*;
#(
    parameter int N_ROWS     = 4,
    parameter int M_COLS     = 4,
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0]     in_data;
    logic                      in_valid;
    logic                      in_ready;
    logic [DATA_WIDTH-1:0]     out_data;
    logic [idx_w(N_ROWS)-1:0]  out_row;
    logic [idx_w(M_COLS)-1:0]  out_col;
    logic                      out_valid;
    logic                      out_ready;
    logic                      busy;
    logic                      done;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_row, out_col, out_valid, busy, done
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_row, out_col, out_valid, busy, done
    );
endinterface

// File: rtl/mac_unit.sv
// mac_unit: single multiply-accumulate; out_word is the running sum reduced to DATA_WIDTH
//           (saturating when DOTINATOR_SATURATE_EN is defined, modulo otherwise)
module mac_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ACC_WIDTH  = 66
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] out_word
);
    logic [2*DATA_WIDTH-1:0] prod;
    logic [ACC_WIDTH-1:0]    acc_q, acc_d, sum;

    // Full-width product and the sum including this cycle's product, so the
    // final term of a dot product can be captured in the same cycle.
    always_comb begin
        prod  = (2*DATA_WIDTH)'(a) * (2*DATA_WIDTH)'(b);
        sum   = acc_q + ACC_WIDTH'(prod);
        acc_d = clear ? '0 : (en ? sum : acc_q);
`ifdef DOTINATOR_SATURATE_EN
        out_word = (|sum[ACC_WIDTH-1:DATA_WIDTH]) ? '1 : sum[DATA_WIDTH-1:0];
`else
        out_word = sum[DATA_WIDTH-1:0];
`endif
    end

    // Accumulator register.
    always_ff @(posedge clk) begin
        if (!rst_n) acc_q <= '0;
        else        acc_q <= acc_d;
    end
endmodule

// File: rtl/seq_matrix_multiplier.sv
// seq_matrix_multiplier: loads A then B, computes R = A x B one product per cycle,
//                        streams R row-major; DOTINATOR_SATURATE_EN selects saturating output
module seq_matrix_multiplier
    import dotinator_pkg::*;
#(
    parameter int N_ROWS     = 4,
    parameter int N_COLS     = 4,
    parameter int M_COLS     = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(N_COLS)
) (
    input  logic               clk,
    input  logic               rst_n,
    seq_matrix_multiplier_if.slave bus
);
    localparam int NA = N_ROWS * N_COLS;
    localparam int NB = N_COLS * M_COLS;
    localparam int NW = load_words(N_ROWS, N_COLS, M_COLS);
    localparam int WW = idx_w(NW);
    localparam int AW = idx_w(NA);
    localparam int BW = idx_w(NB);
    localparam int IW = idx_w(N_ROWS);
    localparam int JW = idx_w(M_COLS);
    localparam int KW = idx_w(N_COLS);

    state_e                state_q, state_d;
    logic [WW-1:0]         w_q, w_d;
    logic [IW-1:0]         i_q, i_d;
    logic [JW-1:0]         j_q, j_d;
    logic [KW-1:0]         k_q, k_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [IW-1:0]         out_row_q, out_row_d;
    logic [JW-1:0]         out_col_q, out_col_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [DATA_WIDTH-1:0] a_mem [NA];
    logic [DATA_WIDTH-1:0] b_mem [NB];
    logic [AW-1:0]         a_addr;
    logic [BW-1:0]         b_addr;
    logic [DATA_WIDTH-1:0] out_word;
    logic                  accept, out_hs, last_w, last_k, last_i, last_j, last_ij;

    assign accept  = bus.in_valid && bus.in_ready;
    assign out_hs  = out_valid_q && bus.out_ready;
    assign last_w  = (w_q == WW'(NW - 1));
    assign last_k  = (k_q == KW'(N_COLS - 1));
    assign last_i  = (i_q == IW'(N_ROWS - 1));
    assign last_j  = (j_q == JW'(M_COLS - 1));
    assign last_ij = last_i && last_j;
    assign a_addr  = AW'(i_q * N_COLS + k_q);
    assign b_addr  = BW'(k_q * M_COLS + j_q);

    assign bus.out_data  = out_data_q;
    assign bus.out_row   = out_row_q;
    assign bus.out_col   = out_col_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

    // The accumulator is held clear outside COMPUTE, so every dot product starts from zero.
    mac_unit #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_mac (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (state_q != COMPUTE),
        .en       (state_q == COMPUTE),
        .a        (a_mem[a_addr]),
        .b        (b_mem[b_addr]),
        .out_word (out_word)
    );

    // Operand buffers; word index w runs through A then B, both row-major.
    always_ff @(posedge clk) begin
        if (accept) begin
            if (w_q < WW'(NA)) a_mem[AW'(w_q)] <= bus.in_data;
            else               b_mem[BW'(w_q - WW'(NA))] <= bus.in_data;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= LOAD;
        else        state_q <= state_d;
    end

    // FSM next state: LOAD -> COMPUTE -> OUTPUT -> COMPUTE or back to LOAD after the last element.
    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD:    if (accept && last_w) state_d = COMPUTE;
            COMPUTE: if (last_k) state_d = OUTPUT;
            OUTPUT:  if (out_hs) state_d = last_ij ? LOAD : COMPUTE;
            default: state_d = LOAD;
        endcase
    end

    // FSM outputs: words are only taken while loading.
    always_comb begin
        bus.in_ready = (state_q == LOAD);
    end

    // Counters, result register and status next-state.
    always_comb begin
        w_d         = w_q;
        i_d         = i_q;
        j_d         = j_q;
        k_d         = k_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_row_d   = out_row_q;
        out_col_d   = out_col_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        if (accept) begin
            w_d    = last_w ? '0 : w_q + 1'b1;
            busy_d = 1'b1;
        end
        if (state_q == COMPUTE) begin
            k_d = last_k ? '0 : k_q + 1'b1;
            if (last_k) begin
                out_valid_d = 1'b1;
                out_data_d  = out_word;
                out_row_d   = i_q;
                out_col_d   = j_q;
            end
        end
        if (out_hs) begin
            out_valid_d = 1'b0;
            j_d         = last_j ? '0 : j_q + 1'b1;
            i_d         = last_j ? (last_i ? '0 : i_q + 1'b1) : i_q;
            busy_d      = last_ij ? 1'b0 : busy_q;
            done_d      = last_ij;
        end
    end

    // Datapath registers; reset discards any partial load or pending result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_q         <= '0;
            i_q         <= '0;
            j_q         <= '0;
            k_q         <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_row_q   <= '0;
            out_col_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            w_q         <= w_d;
            i_q         <= i_d;
            j_q         <= j_d;
            k_q         <= k_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_row_q   <= out_row_d;
            out_col_q   <= out_col_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end
endmodule

// File: tb/tb_seq_matrix_multiplier.sv
// tb_seq_matrix_multiplier: directed bench with a golden-model scoreboard for a 2x2x2/8-bit and a 4x4x4/32-bit instance
module tb_seq_matrix_multiplier;
    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  r;
        logic [1:0]  c;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel;
    logic [31:0] tb_data;
    logic        tb_valid, tb_ready;
    logic [31:0] w [32];
    res_t        sb [$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          done_cnt = 0;

    always #5 clk = ~clk;

    seq_matrix_multiplier_if #(.N_ROWS(2), .M_COLS(2), .DATA_WIDTH(8)) i2 ();
    seq_matrix_multiplier_if i4 ();

    seq_matrix_multiplier #(.N_ROWS(2), .N_COLS(2), .M_COLS(2), .DATA_WIDTH(8)) d2 (
        .clk(clk), .rst_n(rst_n), .bus(i2));
    seq_matrix_multiplier d4 (
        .clk(clk), .rst_n(rst_n), .bus(i4));

    assign i2.in_data   = tb_data[7:0];
    assign i2.in_valid  = !sel && tb_valid;
    assign i2.out_ready = !sel && tb_ready;
    assign i4.in_data   = tb_data;
    assign i4.in_valid  = sel && tb_valid;
    assign i4.out_ready = sel && tb_ready;

    logic [31:0] o_data;
    logic [1:0]  o_row, o_col;
    logic        o_valid, o_inrdy, o_busy, o_done;
    assign o_data  = sel ? i4.out_data : {24'h0, i2.out_data};
    assign o_row   = sel ? i4.out_row : {1'b0, i2.out_row};
    assign o_col   = sel ? i4.out_col : {1'b0, i2.out_col};
    assign o_valid = sel ? i4.out_valid : i2.out_valid;
    assign o_inrdy = sel ? i4.in_ready : i2.in_ready;
    assign o_busy  = sel ? i4.busy : i2.busy;
    assign o_done  = sel ? i4.done : i2.done;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (i2.done || i4.done) done_cnt <= done_cnt + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_check(input string t);
        chk({t, "_in_ready2"}, i2.in_ready, 1);
        chk({t, "_out_valid2"}, i2.out_valid, 0);
        chk({t, "_out_data2"}, i2.out_data, 0);
        chk({t, "_out_rc2"}, {i2.out_row, i2.out_col}, 0);
        chk({t, "_busy_done2"}, {i2.busy, i2.done}, 0);
        chk({t, "_in_ready4"}, i4.in_ready, 1);
        chk({t, "_out_valid4"}, i4.out_valid, 0);
        chk({t, "_out_data4"}, i4.out_data, 0);
        chk({t, "_out_rc4"}, {i4.out_row, i4.out_col}, 0);
        chk({t, "_busy_done4"}, {i4.busy, i4.done}, 0);
    endtask

    // Golden model: plain triple loop over the load-word image in w.
    task automatic model(input int nr, input int nc, input int mc, input int dw);
        logic [95:0] s;
        logic [63:0] lim;
        res_t        e;
        lim = 64'd1 << dw;
        for (int r = 0; r < nr; r++) begin
            for (int c = 0; c < mc; c++) begin
                s = '0;
                for (int k = 0; k < nc; k++) s += 96'(w[r*nc+k]) * 96'(w[nr*nc+k*mc+c]);
`ifdef DOTINATOR_SATURATE_EN
                e.d = (s >= 96'(lim)) ? 32'(lim - 64'd1) : 32'(s[63:0] & (lim - 64'd1));
`else
                e.d = 32'(s[63:0] & (lim - 64'd1));
`endif
                e.r = 2'(r);
                e.c = 2'(c);
                sb.push_back(e);
            end
        end
    endtask

    task automatic load(input int nw, input bit rnd);
        int n = 0;
        int g = 0;
        bit v, hs;
        while (n < nw && g < 1000) begin
            @(negedge clk);
            v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tb_valid = v;
            tb_data = v ? w[n] : $urandom;
            hs = v && o_inrdy;
            @(posedge clk);
            if (hs) n++;
            g++;
        end
        chk("load_beats", n, nw);
    endtask

    task automatic lat(input int nc, input bit junk);
        int c = 0;
        do begin
            @(negedge clk);
            tb_valid = junk;
            tb_data = $urandom;
            c++;
        end while (!o_valid && c < 100);
        chk("first_latency", c, nc + 1);
        chk("busy_high", o_busy, 1);
        chk("in_ready_low", o_inrdy, 0);
    endtask

    task automatic drain(input int cnt, input int stall_at, input int stall_len,
                         input bit junk, input bit per, input int nc);
        int got = 0;
        int stl = 0;
        int g = 0;
        int last_cyc = 0;
        logic [31:0] cd;
        logic [1:0]  cr, cc;
        res_t e;
        done_cnt = 0;
        while (got < cnt && g < 3000) begin
            tb_valid = junk && (got < cnt - 1);
            tb_data = $urandom;
            if (o_valid && got == stall_at && stl < stall_len) begin
                tb_ready = 1'b0;
                if (stl == 0) begin
                    cd = o_data;
                    cr = o_row;
                    cc = o_col;
                end else begin
                    chk("stall_stable", {o_data, o_row, o_col}, {cd, cr, cc});
                end
                chk("stall_in_ready", o_inrdy, 0);
                stl++;
            end else begin
                tb_ready = 1'b1;
                if (o_valid && sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("out_data", o_data, e.d);
                    chk("out_row_col", {o_row, o_col}, {e.r, e.c});
                    if (per && got > 0) chk("result_period", cyc - last_cyc, nc + 1);
                    last_cyc = cyc;
                    got++;
                end
            end
            @(negedge clk);
            g++;
        end
        tb_ready = 1'b0;
        tb_valid = 1'b0;
        chk("drain_count", got, cnt);
        chk("done_pulse", o_done, 1);
        chk("busy_low", o_busy, 0);
        @(negedge clk);
        chk("done_clear", o_done, 0);
        #1 chk("done_once", done_cnt, 1);
    endtask

    initial begin
        sel = 1'b0;
        tb_valid = 1'b0;
        tb_ready = 1'b0;
        tb_data = '0;
        repeat (2) @(negedge clk);
        reset_check("por");
        rst_n = 1'b1;

        // 2x2x2: A=[[1,2],[3,4]], B=[[5,6],[7,8]] -> 19,22,43,50
        for (int n = 0; n < 8; n++) w[n] = 32'(n + 1);
        model(2, 2, 2, 8);
        load(8, 0);
        lat(2, 0);
        drain(4, -1, 0, 0, 1, 2);

        // 4x4x4: A=identity, B=1..16 -> R=1..16, one result every 5 cycles
        sel = 1'b1;
        for (int n = 0; n < 16; n++) w[n] = (n / 4 == n % 4) ? 32'd1 : 32'd0;
        for (int n = 0; n < 16; n++) w[16+n] = 32'(n + 1);
        model(4, 4, 4, 32);
        load(32, 0);
        lat(4, 0);
        drain(16, -1, 0, 0, 1, 4);

        // 4x4x4 random operands, second result held off for 7 cycles
        for (int n = 0; n < 32; n++) w[n] = $urandom_range(0, 1000);
        model(4, 4, 4, 32);
        load(32, 0);
        lat(4, 0);
        drain(16, 1, 7, 0, 0, 4);

        // 8-bit overflow: all elements 255
        sel = 1'b0;
        for (int n = 0; n < 8; n++) w[n] = 32'd255;
        model(2, 2, 2, 8);
        load(8, 0);
        lat(2, 0);
        drain(4, -1, 0, 0, 1, 2);

        // Reset after 5 of 8 load words, then a clean reload
        for (int n = 0; n < 8; n++) w[n] = $urandom_range(0, 255);
        load(5, 0);
        @(negedge clk);
        tb_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        reset_check("mid_load");
        rst_n = 1'b1;
        for (int n = 0; n < 8; n++) w[n] = 32'(n + 1);
        model(2, 2, 2, 8);
        load(8, 0);
        lat(2, 0);
        drain(4, -1, 0, 0, 1, 2);

        // Random in_valid gaps during load, in_valid held high with junk during compute/output
        for (int n = 0; n < 8; n++) w[n] = $urandom_range(0, 255);
        model(2, 2, 2, 8);
        load(8, 1);
        lat(2, 1);
        drain(4, -1, 0, 1, 0, 2);

        chk("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
